// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: default sizing,
// FSM state encodings and the round-robin index wrap helper.
package uart_tx_arbiter_pkg;

  // Default sizing of the arbiter
  localparam int DEF_NUM_REQ     = 2;
  localparam int DEF_WORD_W      = 8;
  localparam int DEF_MIN_HOLD    = 2;
  localparam int DEF_TIMEOUT_CYC = 4096;

  // FSM state encodings (plain constants for legacy tool compatibility)
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_HOLD      = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  // Wrap an index that may run at most one lap past n back into 0..n-1
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: searches req_valid starting one
// position after the pointer (wrapping) and returns the first hit.
module uart_tx_arbiter_rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
  output logic                       any_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand_s;
  logic             found_s;

  // First valid requester after the pointer, lowest search distance wins
  always_comb begin
    grant_idx_o = '0;
    found_s     = 1'b0;
    cand_s      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = IDX_W'(rr_wrap(int'(ptr_i) + k, NUM_REQ));
      if (!found_s && req_valid_i[cand_s]) begin
        found_s     = 1'b1;
        grant_idx_o = cand_s;
      end else begin
        found_s     = found_s;
      end
    end
    any_o = found_s;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte
// sources. Grants one byte at a time round-robin, latches it onto tx_word
// and drives the transmitter's level-sensitive start until it reports done.
// Optional WAIT_DONE watchdog: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int WORD_W      = DEF_WORD_W,
  parameter int MIN_HOLD    = DEF_MIN_HOLD,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WORD_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [WORD_W-1:0]           tx_word,
  output logic                        tx_start,
  input  logic                        tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        err_timeout
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(MIN_HOLD + 1);

  logic [1:0]         state_q,     state_d;
  logic [IDX_W-1:0]   ptr_q,       ptr_d;
  logic [IDX_W-1:0]   grant_id_q,  grant_id_d;
  logic [WORD_W-1:0]  tx_word_q,   tx_word_d;
  logic               tx_start_q,  tx_start_d;
  logic               busy_q,      busy_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;

  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0]  wait_cnt_q,  wait_cnt_d;
  logic               err_q,       err_d;
`endif

  uart_tx_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_valid_i (req_valid),
    .ptr_i       (ptr_q),
    .grant_idx_o (pick_idx_s),
    .any_o       (pick_any_s)
  );

  // Next-state logic for the grant/hold/wait/gap sequence
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    tx_word_d   = tx_word_q;
    tx_start_d  = tx_start_q;
    busy_d      = busy_q;
    req_ready_d = '0;
    hold_cnt_d  = hold_cnt_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          tx_word_d   = req_data[pick_idx_s*WORD_W +: WORD_W];
          grant_id_d  = pick_idx_s;
          ptr_d       = pick_idx_s;
          tx_start_d  = 1'b1;
          busy_d      = 1'b1;
          req_ready_d = NUM_REQ'(1) << pick_idx_s;
          hold_cnt_d  = '0;
          state_d     = ST_HOLD;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // tx_ready may still show the previous byte's done here; ignore it
        if (hold_cnt_q == HOLD_W'(MIN_HOLD - 1)) begin
          hold_cnt_d = '0;
          state_d    = ST_WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (tx_ready) begin
          tx_start_d = 1'b0;
          state_d    = ST_GAP;
`ifdef UART_TX_ARB_TIMEOUT_EN
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
          tx_start_d = 1'b0;
          err_d      = 1'b1;
          state_d    = ST_GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
`else
        end else begin
          state_d    = ST_WAIT_DONE;
        end
`endif
      end
      ST_GAP: begin
        // One idle cycle so the transmitter sees start deasserted
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        tx_start_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      grant_id_q  <= '0;
      tx_word_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= '0;
      hold_cnt_q  <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      tx_word_q   <= tx_word_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
      hold_cnt_q  <= hold_cnt_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign tx_word   = tx_word_q;
  assign tx_start  = tx_start_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule
